regfile_writeback: RTL and testbench

Writeback stage of the NPC core: arbitrates results from the EXU (single-cycle ALU results) and the LSU (variable-latency load data) onto the single write port of the register file, one write per cycle. It keeps a load scoreboard so decode can stall on registers with outstanding loads. It also provides a one-entry bypass of the in-flight write, covering the cycle before the register file holds the new value.

---
 rtl/regfile_writeback.sv | 100 ++++++++++
 tb/tb_regfile_writeback.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback stage: LSU > EXU arbitration onto the single register file write port,
// with a load scoreboard for decode stalls and a one-entry bypass of the in-flight write.
module regfile_writeback #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  ld_issue,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [DATA_WIDTH-1:0] byp_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  sb_err
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic                  lsu_xfer;
    logic                  exu_xfer;
    logic                  wr_take;
    logic [ADDR_WIDTH-1:0] wr_rd;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NumRegs-1:0]    pending_q;
    logic [NumRegs-1:0]    pending_d;
    logic                  ld_live;

    assign lsu_ready = !rst;
    assign exu_ready = !rst && !lsu_valid;
    assign lsu_xfer  = lsu_valid && lsu_ready;
    assign exu_xfer  = exu_valid && exu_ready;
    assign ld_live   = ld_issue && (ld_rd != '0);

    always_comb begin
        wr_take = 1'b0;
        wr_rd   = exu_rd;
        wr_data = exu_data;
        if (lsu_xfer) begin
            wr_take = 1'b1;
            wr_rd   = lsu_rd;
            wr_data = lsu_data;
        end else if (exu_xfer) begin
            wr_take = 1'b1;
        end
    end

    // Clear before set so a load re-issued to the returning register stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (lsu_xfer) begin
            pending_d[lsu_rd] = 1'b0;
        end
        if (ld_live) begin
            pending_d[ld_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            pending_q <= '0;
            sb_err    <= 1'b0;
        end else begin
            wen <= wr_take && (wr_rd != '0);
            if (wr_take) begin
                waddr <= wr_rd;
                wdata <= wr_data;
            end
            pending_q <= pending_d;
            if (ld_live && pending_q[ld_rd]) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign busy1    = pending_q[raddr1];
    assign busy2    = pending_q[raddr2];
    assign byp_hit1 = wen && (waddr == raddr1) && (raddr1 != '0);
    assign byp_hit2 = wen && (waddr == raddr2) && (raddr2 != '0);
    assign byp_data = wdata;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic, all checked
// against an architectural model (last accepted value per register, outstanding-load set).
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_valid, ld_issue;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd, lsu_rd, ld_rd, raddr1, raddr2, waddr;
    logic [31:0] exu_data, lsu_data, byp_data, wdata;
    logic        busy1, busy2, byp_hit1, byp_hit2, wen, sb_err;

    always #5 clk = ~clk;

    regfile_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .raddr1(raddr1), .raddr2(raddr2),
        .busy1(busy1), .busy2(busy2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data(byp_data), .wen(wen), .waddr(waddr), .wdata(wdata), .sb_err(sb_err)
    );

    // Register file sitting behind the write port, as decode would see it.
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (wen && waddr != 0) rf[waddr] <= wdata;

    // Architectural model.
    logic [31:0] m_arch [32];
    bit          m_pend [32];
    bit          m_wen, m_err;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] view(input logic [4:0] a, input logic hit);
        if (hit) return byp_data;
        return (a == 0) ? 32'h0 : rf[a];
    endfunction

    function automatic logic [31:0] arch(input logic [4:0] a);
        return (a == 0) ? 32'h0 : m_arch[a];
    endfunction

    task automatic model_reset();
        m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    // One clock: apply inputs just after negedge, check combinational outputs,
    // advance model, check registered outputs after posedge, return at next negedge.
    task automatic step(input logic r,
                        input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic li, input logic [4:0] lir,
                        input logic [4:0] a1, input logic [4:0] a2);
        bit         take;
        logic [4:0] trd;
        logic [31:0] tdat;
        rst = r; exu_valid = ev; exu_rd = erd; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        ld_issue = li; ld_rd = lir; raddr1 = a1; raddr2 = a2;
        #1;
        check_eq("lsu_ready", lsu_ready, !r);
        check_eq("exu_ready", exu_ready, !r && !lv);
        check_eq("busy1", busy1, m_pend[a1]);
        check_eq("busy2", busy2, m_pend[a2]);
        check_eq("byp_hit1", byp_hit1, m_wen && m_waddr == a1 && a1 != 0);
        check_eq("byp_hit2", byp_hit2, m_wen && m_waddr == a2 && a2 != 0);
        if (m_wen) check_eq("byp_data", byp_data, m_wdata);
        check_eq("view1", view(a1, byp_hit1), arch(a1));
        check_eq("view2", view(a2, byp_hit2), arch(a2));
        if (r) begin
            model_reset();
        end else begin
            take = lv || ev;
            trd  = lv ? lrd : erd;
            tdat = lv ? ld : ed;
            m_wen = take && trd != 0;
            if (m_wen) begin
                m_waddr = trd; m_wdata = tdat; m_arch[trd] = tdat;
            end
            if (li && lir != 0 && m_pend[lir]) m_err = 1;
            if (lv) m_pend[lrd] = 0;
            if (li && lir != 0) m_pend[lir] = 1;
            m_pend[0] = 0;
        end
        @(posedge clk); #1;
        check_eq("wen", wen, m_wen);
        check_eq("sb_err", sb_err, m_err);
        if (m_wen) begin
            check_eq("waddr", waddr, m_waddr);
            check_eq("wdata", wdata, m_wdata);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    initial begin
        bit         e_v, l_v, r_v, li_v, e_hold, l_hold;
        logic [4:0] e_r, l_r, li_r;
        logic [31:0] e_d, l_d;

        for (int i = 0; i < 32; i++) m_arch[i] = '0;
        rst = 1; exu_valid = 0; lsu_valid = 0; ld_issue = 0;
        exu_rd = 0; lsu_rd = 0; ld_rd = 0; exu_data = 0; lsu_data = 0; raddr1 = 0; raddr2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_eq("rst_wen", wen, 0);
        check_eq("rst_waddr", waddr, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_sb_err", sb_err, 0);
        check_eq("rst_exu_ready", exu_ready, 0);
        check_eq("rst_lsu_ready", lsu_ready, 0);

        // EXU write, bypass in T+1, register file from T+2.
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        check_eq("t1_wen", wen, 1);
        check_eq("t1_waddr", waddr, 5);
        check_eq("t1_wdata", wdata, 32'hDEADBEEF);
        check_eq("t1_hit", byp_hit1, 1);
        idle(5, 0);
        check_eq("t1_wen_off", wen, 0);
        check_eq("t1_rf", rf[5], 32'hDEADBEEF);

        // LSU wins; EXU follows next cycle.
        step(0, 1, 4, 32'h22, 1, 3, 32'h11, 0, 0, 3, 4);
        check_eq("t2_waddr_a", waddr, 3);
        check_eq("t2_wdata_a", wdata, 32'h11);
        step(0, 1, 4, 32'h22, 0, 0, 0, 0, 0, 3, 4);
        check_eq("t2_waddr_b", waddr, 4);
        check_eq("t2_wdata_b", wdata, 32'h22);

        // Load scoreboard and no-gap handover to bypass.
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        check_eq("t3_busy", busy1, 1);
        idle(7, 0);
        step(0, 0, 0, 0, 1, 7, 32'hABCD, 0, 0, 7, 0);
        check_eq("t3_busy_off", busy1, 0);
        check_eq("t3_hit", byp_hit1, 1);
        check_eq("t3_byp", byp_data, 32'hABCD);

        // x0 writes dropped, x0 never busy.
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        check_eq("t4_wen", wen, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("t4_busy0", busy1, 0);

        // Double issue flags sb_err; issue+return on same reg keeps pending.
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        check_eq("t5_err", sb_err, 1);
        step(0, 0, 0, 0, 1, 9, 32'h55, 1, 9, 9, 0);
        check_eq("t5_busy", busy1, 1);
        check_eq("t5_err_held", sb_err, 1);

        // Reset with pending bits and wen=1.
        step(0, 0, 0, 0, 0, 0, 0, 1, 12, 9, 12);
        step(1, 1, 6, 32'h66, 1, 8, 32'h88, 0, 0, 9, 12);
        check_eq("t6_wen", wen, 0);
        check_eq("t6_busy1", busy1, 0);
        check_eq("t6_busy2", busy2, 0);
        check_eq("t6_err", sb_err, 0);

        // Random traffic with source hold semantics.
        e_hold = 0; l_hold = 0;
        e_v = 0; l_v = 0; e_r = 0; l_r = 0; e_d = 0; l_d = 0;
        for (int i = 0; i < 3000; i++) begin
            r_v = ($urandom_range(0, 59) == 0);
            if (!e_hold) begin
                e_v = ($urandom_range(0, 2) != 0);
                e_r = 5'($urandom_range(0, 7));
                e_d = $urandom;
            end
            if (!l_hold) begin
                l_v = ($urandom_range(0, 2) == 0);
                l_r = 5'($urandom_range(0, 7));
                l_d = $urandom;
            end
            li_v = ($urandom_range(0, 3) == 0);
            li_r = 5'($urandom_range(0, 7));
            step(r_v, e_v, e_r, e_d, l_v, l_r, l_d, li_v, li_r,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            e_hold = e_v && (r_v || l_v);
            l_hold = l_v && r_v;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
